if_pc_ctrl: RTL and testbench
=============================

Name: if_pc_ctrl

Overview:
- Fetch-side program-counter and redirect controller. It is the consumer of the EX-stage branch/jump resolution outputs.
- Holds the architectural fetch PC and issues single-outstanding requests to instruction memory.
- Delivers fetched PCs to decode.
- On a jump or branch taken from EX: redirects the PC, kills younger stages, and discards any stale in-flight fetch response.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, fetch address loaded on reset.
- C_EXT, 1, compressed support; 1 = 2-byte target alignment legal, 0 = 4-byte alignment required.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_ex_jump_taken  in  1  JAL/JALR resolved in EX.
- i_ex_branch_taken  in  1  conditional branch taken in EX.
- i_ex_jump_target  in  64  jump destination.
- i_ex_branch_target  in  64  branch destination.
- i_stall  in  1  decode cannot accept an instruction this cycle.
- i_fetch_compr  in  1  instruction returned this cycle is 16-bit; qualified by i_imem_rvalid.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  64  fetch address; equals o_pc.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response for the accepted request.
- o_pc  out  64  current fetch PC.
- o_valid  out  1  instruction at o_pc is valid to decode.
- o_flush  out  1  kill IF/ID and ID/EX contents this cycle.
- o_misalign_exc  out  1  one-cycle pulse: illegal redirect target.
- o_exc_addr  out  64  offending target, valid with o_misalign_exc.

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT, pc=RESET_PC.
  - o_imem_req, o_valid, o_flush and o_misalign_exc are 0; o_exc_addr=0.
- Redirect decode:
  - redir = jump_taken | branch_taken.
  - tgt = jump_taken ? jump_target : branch_target; jump wins if both are set.
- Redirect acceptance:
  - Accepted the cycle it is asserted, independent of i_stall.
  - o_flush = redir, combinational, same cycle.
  - pc <= tgt at the next edge.
- Misaligned targets (tgt[0]=1, or C_EXT=0 and tgt[1]=1):
  - o_misalign_exc=1 and o_exc_addr=tgt, registered, the next cycle.
  - pc unchanged; o_flush still asserted.
  - The state transitions below still apply.
- FSM states: BOOT, REQ, WAIT, HOLD, DRAIN.
  - BOOT: o_imem_req=0. Goes to REQ the first cycle after reset release.
  - REQ: o_imem_req=1, o_imem_addr=pc.
    - gnt -> WAIT.
    - redir and no gnt -> REQ at the new pc. The address may change while ungranted.
    - redir with gnt -> DRAIN.
  - WAIT: o_imem_req=0.
    - rvalid and no redir: o_valid=1, o_pc=pc for this cycle.
      - If !i_stall: pc += i_fetch_compr ? 2 : 4, go to REQ.
      - If i_stall: go to HOLD.
    - redir, no rvalid -> DRAIN.
    - redir and rvalid same cycle: response discarded, o_valid=0, go to REQ.
  - HOLD: o_valid=1 and o_pc stable; the compr flag is latched on entry.
    - When !i_stall: advance pc by the latched size, go to REQ.
    - redir -> o_valid=0 next cycle, go to REQ at tgt.
  - DRAIN: o_valid=0; waiting for the stale response.
    - rvalid -> REQ.
    - redir in DRAIN: pc updated, stay in DRAIN.
- Throughput and latency: one instruction per 2 cycles minimum (REQ+WAIT with same-cycle gnt/rvalid). Latency from gnt to o_valid is one cycle or more.
- PC arithmetic is 64-bit modulo 2^64; wrap at 0xFFFF_FFFF_FFFF_FFFC+4 -> 0 is legal, no exception.
- rst_n assertion in any state, including mid-WAIT or DRAIN:
  - Immediately forces the reset values.
  - Any response returning afterwards is ignored because BOOT does not sample rvalid.
  - The imem side is reset by the same rst_n.

Decomposition:
- Shared package struct_pckg:
  - typedef enum for the FSM states (fetch_state_t).
  - typedef struct redirect_struct {valid, misalign, target[63:0]}.
- defines.sv: reuse RNG_64; add INSTR_SZ_C=2 and INSTR_SZ_I=4.
- One combinational sub-module, if_redirect_sel:
  - Does the jump/branch priority mux and the alignment check.
  - Returns redirect_struct.
- The FSM and PC register stay in if_pc_ctrl.

Test Plan:
- Reset release, gnt and rvalid held at 1, i_fetch_compr=0, no stall -> o_pc sequence 0,4,8,C; o_valid high every second cycle.
- Fetch at 0x100 with rvalid and i_fetch_compr=1 -> next request address 0x102; same with compr=0 -> 0x104.
- In WAIT, i_ex_branch_taken=1 with target 0x2000 and no rvalid:
  - o_flush=1 that cycle; the next rvalid is dropped (o_valid=0).
  - The next o_imem_addr is 0x2000.
- Jump and branch taken in the same cycle (jump target 0x3000, branch target 0x4000) -> pc=0x3000.
- C_EXT=0, jump target 0x1002:
  - o_misalign_exc=1 with o_exc_addr=0x1002 for exactly one cycle.
  - pc unchanged; o_flush=1.
- i_stall held 3 cycles after rvalid at pc 0x40 -> o_valid=1 and o_pc=0x40 stable for 3 cycles; advances to 0x44 after stall drops. Then rst_n pulsed low mid-WAIT -> pc=RESET_PC and all outputs 0 asynchronously.

Source files
------------

// File: rtl/struct_pckg.sv
// Types shared by the fetch PC controller and its redirect selector.
`include "defines.sv"
package struct_pckg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic            misalign;
    logic [`RNG_64]  target;
  } redirect_struct;

  function automatic logic [`RNG_64] instr_step(input logic compr);
    return compr ? 64'(`INSTR_SZ_C) : 64'(`INSTR_SZ_I);
  endfunction

endpackage

// File: rtl/defines.sv
// Shared bit-range and instruction-size macros for the fetch front end.
`ifndef DEFINES_SV
`define DEFINES_SV
`define RNG_64 63:0
`define INSTR_SZ_C 2
`define INSTR_SZ_I 4
`endif

// File: rtl/if_redirect_sel.sv
// Jump/branch redirect priority mux plus target alignment check.
// Purely combinational; no flow control.
module if_redirect_sel
  import struct_pckg::*;
#(
  parameter bit C_EXT = 1'b1
) (
  input  logic            jump_taken,
  input  logic            branch_taken,
  input  logic [`RNG_64]  jump_target,
  input  logic [`RNG_64]  branch_target,
  output redirect_struct  redir
);

  logic [`RNG_64] tgt;

  always_comb begin
    tgt            = jump_taken ? jump_target : branch_target;
    redir.valid    = jump_taken | branch_taken;
    redir.target   = tgt;
    // Half-word targets are only legal when compressed instructions exist.
    redir.misalign = tgt[0] | (!C_EXT & tgt[1]);
  end

endmodule

// File: rtl/if_pc_ctrl.sv
// Fetch PC register and single-outstanding imem request FSM with EX redirects.
// Min two cycles per instruction (REQ+WAIT); i_stall parks a delivered PC in HOLD.
module if_pc_ctrl
  import struct_pckg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter bit          C_EXT    = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_ex_jump_taken,
  input  logic           i_ex_branch_taken,
  input  logic [`RNG_64] i_ex_jump_target,
  input  logic [`RNG_64] i_ex_branch_target,
  input  logic           i_stall,
  input  logic           i_fetch_compr,
  output logic           o_imem_req,
  output logic [`RNG_64] o_imem_addr,
  input  logic           i_imem_gnt,
  input  logic           i_imem_rvalid,
  output logic [`RNG_64] o_pc,
  output logic           o_valid,
  output logic           o_flush,
  output logic           o_misalign_exc,
  output logic [`RNG_64] o_exc_addr
);

  fetch_state_t   state, state_nxt;
  logic [`RNG_64] pc, pc_nxt;
  logic           hold_compr, hold_compr_nxt;
  redirect_struct redir;

  if_redirect_sel #(.C_EXT(C_EXT)) u_redirect_sel (
    .jump_taken    (i_ex_jump_taken),
    .branch_taken  (i_ex_branch_taken),
    .jump_target   (i_ex_jump_target),
    .branch_target (i_ex_branch_target),
    .redir         (redir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      hold_compr     <= 1'b0;
      o_misalign_exc <= 1'b0;
      o_exc_addr     <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      hold_compr     <= hold_compr_nxt;
      o_misalign_exc <= redir.valid & redir.misalign;
      if (redir.valid && redir.misalign)
        o_exc_addr <= redir.target;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_compr_nxt = hold_compr;
    o_imem_req     = 1'b0;
    o_valid        = 1'b0;
    unique case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_gnt)
          state_nxt = redir.valid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redir.valid) begin
          // A response landing with the redirect is stale; nothing remains in flight.
          state_nxt = i_imem_rvalid ? REQ : DRAIN;
        end else if (i_imem_rvalid) begin
          o_valid = 1'b1;
          if (!i_stall) begin
            pc_nxt    = pc + instr_step(i_fetch_compr);
            state_nxt = REQ;
          end else begin
            hold_compr_nxt = i_fetch_compr;
            state_nxt      = HOLD;
          end
        end
      end
      HOLD: begin
        o_valid = 1'b1;
        if (redir.valid) begin
          state_nxt = REQ;
        end else if (!i_stall) begin
          pc_nxt    = pc + instr_step(hold_compr);
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (i_imem_rvalid)
          state_nxt = REQ;
      end
      default: state_nxt = BOOT;
    endcase
    // Illegal targets still flush and steer the FSM but leave the PC alone.
    if (redir.valid && !redir.misalign)
      pc_nxt = redir.target;
  end

  assign o_flush     = redir.valid;
  assign o_pc        = pc;
  assign o_imem_addr = pc;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl: dut0 has C_EXT=0, dut1 has C_EXT=1, same stimulus.
module tb_if_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_taken, branch_taken, stall, fetch_compr, gnt, rvalid;
  logic [63:0] jump_target, branch_target;

  logic        req0, valid0, flush0, exc0;
  logic [63:0] addr0, pc0, exc_addr0;
  logic        req1, valid1, flush1, exc1;
  logic [63:0] addr1, pc1, exc_addr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_pc_ctrl #(.RESET_PC(64'h0), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_ex_jump_taken(jump_taken), .i_ex_branch_taken(branch_taken),
    .i_ex_jump_target(jump_target), .i_ex_branch_target(branch_target),
    .i_stall(stall), .i_fetch_compr(fetch_compr),
    .o_imem_req(req0), .o_imem_addr(addr0),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .o_pc(pc0), .o_valid(valid0), .o_flush(flush0),
    .o_misalign_exc(exc0), .o_exc_addr(exc_addr0)
  );

  if_pc_ctrl #(.RESET_PC(64'h0), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_ex_jump_taken(jump_taken), .i_ex_branch_taken(branch_taken),
    .i_ex_jump_target(jump_target), .i_ex_branch_target(branch_target),
    .i_stall(stall), .i_fetch_compr(fetch_compr),
    .o_imem_req(req1), .o_imem_addr(addr1),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid),
    .o_pc(pc1), .o_valid(valid1), .o_flush(flush1),
    .o_misalign_exc(exc1), .o_exc_addr(exc_addr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump_taken = 0; branch_taken = 0; stall = 0; fetch_compr = 0;
    gnt = 0; rvalid = 0; jump_target = '0; branch_target = '0;
  endtask

  // Leaves both DUTs in REQ at pc 0, 1ns after an edge.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  // From REQ with gnt low: redirect the request address to tgt.
  task automatic jump_to(input logic [63:0] tgt);
    gnt = 0; jump_taken = 1; jump_target = tgt;
    tick();
    jump_taken = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    checks++;
    if (req0 !== 0 || valid0 !== 0 || flush0 !== 0 || exc0 !== 0 || exc_addr0 !== 64'h0 || pc0 !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b valid=%b flush=%b exc=%b exc_addr=%h pc=%h, required all zero",
               req0, valid0, flush0, exc0, exc_addr0, pc0);
    end
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (req0 !== 0) begin failures++; $display("FAIL boot_no_req: req=%b required 0", req0); end
    tick();
    checks++;
    if (req0 !== 1 || addr0 !== 64'h0) begin
      failures++; $display("FAIL boot_to_req: req=%b addr=%h required 1 / 0", req0, addr0);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'h0; exp_pc[1] = 64'h4; exp_pc[2] = 64'h8; exp_pc[3] = 64'hC;
    do_reset();
    gnt = 1; rvalid = 1; fetch_compr = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req0 !== 1 || valid0 !== 0 || addr0 !== exp_pc[i]) begin
        failures++;
        $display("FAIL seq_req[%0d]: req=%b valid=%b addr=%h required 1 0 %h", i, req0, valid0, addr0, exp_pc[i]);
      end
      tick();
      checks++;
      if (req0 !== 0 || valid0 !== 1 || pc0 !== exp_pc[i]) begin
        failures++;
        $display("FAIL seq_valid[%0d]: req=%b valid=%b pc=%h required 0 1 %h", i, req0, valid0, pc0, exp_pc[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_compr();
    do_reset();
    gnt = 0; jump_taken = 1; jump_target = 64'h100;
    #1;
    checks++;
    if (flush0 !== 1) begin failures++; $display("FAIL compr_flush: flush=%b required 1", flush0); end
    tick();
    jump_taken = 0;
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; fetch_compr = 1;
    #1;
    checks++;
    if (valid0 !== 1 || pc0 !== 64'h100) begin
      failures++; $display("FAIL compr_deliver: valid=%b pc=%h required 1 100", valid0, pc0);
    end
    tick();
    rvalid = 0; fetch_compr = 0;
    #1;
    checks++;
    if (req0 !== 1 || addr0 !== 64'h102) begin
      failures++; $display("FAIL compr_next: req=%b addr=%h required 1 102", req0, addr0);
    end
    jump_to(64'h100);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; fetch_compr = 0;
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (req0 !== 1 || addr0 !== 64'h104) begin
      failures++; $display("FAIL full_next: req=%b addr=%h required 1 104", req0, addr0);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    gnt = 1;
    tick();
    gnt = 0; branch_taken = 1; branch_target = 64'h2000;
    #1;
    checks++;
    if (flush0 !== 1 || valid0 !== 0) begin
      failures++; $display("FAIL wait_redir_flush: flush=%b valid=%b required 1 0", flush0, valid0);
    end
    tick();
    branch_taken = 0;
    #1;
    checks++;
    if (req0 !== 0 || flush0 !== 0) begin
      failures++; $display("FAIL drain_idle: req=%b flush=%b required 0 0", req0, flush0);
    end
    rvalid = 1;
    #1;
    checks++;
    if (valid0 !== 0) begin failures++; $display("FAIL drain_drop: valid=%b required 0", valid0); end
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (req0 !== 1 || addr0 !== 64'h2000) begin
      failures++; $display("FAIL redir_addr: req=%b addr=%h required 1 2000", req0, addr0);
    end
  endtask

  task automatic test_priority();
    do_reset();
    gnt = 0; jump_taken = 1; jump_target = 64'h3000; branch_taken = 1; branch_target = 64'h4000;
    tick();
    jump_taken = 0; branch_taken = 0;
    #1;
    checks++;
    if (pc0 !== 64'h3000 || addr0 !== 64'h3000 || req0 !== 1) begin
      failures++; $display("FAIL jump_priority: pc=%h addr=%h req=%b required 3000 3000 1", pc0, addr0, req0);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    gnt = 0; jump_taken = 1; jump_target = 64'h1002;
    #1;
    checks++;
    if (flush0 !== 1 || exc0 !== 0) begin
      failures++; $display("FAIL misalign_same_cycle: flush=%b exc=%b required 1 0", flush0, exc0);
    end
    tick();
    jump_taken = 0;
    #1;
    checks++;
    if (exc0 !== 1 || exc_addr0 !== 64'h1002 || pc0 !== 64'h0) begin
      failures++; $display("FAIL misalign_exc: exc=%b exc_addr=%h pc=%h required 1 1002 0", exc0, exc_addr0, pc0);
    end
    checks++;
    if (exc1 !== 0 || pc1 !== 64'h1002) begin
      failures++; $display("FAIL cext_half_ok: exc=%b pc=%h required 0 1002", exc1, pc1);
    end
    tick();
    checks++;
    if (exc0 !== 0) begin failures++; $display("FAIL misalign_pulse_len: exc=%b required 0", exc0); end
    jump_taken = 1; jump_target = 64'h1001;
    tick();
    jump_taken = 0;
    #1;
    checks++;
    if (exc1 !== 1 || exc_addr1 !== 64'h1001 || pc1 !== 64'h1002) begin
      failures++; $display("FAIL odd_target: exc=%b exc_addr=%h pc=%h required 1 1001 1002", exc1, exc_addr1, pc1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_to(64'hFFFF_FFFF_FFFF_FFFC);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; fetch_compr = 0;
    tick();
    rvalid = 0;
    #1;
    checks++;
    if (addr0 !== 64'h0 || req0 !== 1 || exc0 !== 0) begin
      failures++; $display("FAIL pc_wrap: addr=%h req=%b exc=%b required 0 1 0", addr0, req0, exc0);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    jump_to(64'h40);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; stall = 1; fetch_compr = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (valid0 !== 1 || pc0 !== 64'h40) begin
        failures++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h required 1 40", i, valid0, pc0);
      end
      tick();
      rvalid = 0;
    end
    stall = 0;
    #1;
    checks++;
    if (valid0 !== 1 || pc0 !== 64'h40) begin
      failures++; $display("FAIL stall_release: valid=%b pc=%h required 1 40", valid0, pc0);
    end
    tick();
    checks++;
    if (req0 !== 1 || addr0 !== 64'h44 || valid0 !== 0) begin
      failures++; $display("FAIL stall_advance: req=%b addr=%h valid=%b required 1 44 0", req0, addr0, valid0);
    end
    gnt = 1;
    tick();
    gnt = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pc0 !== 64'h0 || req0 !== 0 || valid0 !== 0 || flush0 !== 0 || exc0 !== 0) begin
      failures++;
      $display("FAIL async_reset: pc=%h req=%b valid=%b flush=%b exc=%b required all zero",
               pc0, req0, valid0, flush0, exc0);
    end
    rvalid = 1;
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (valid0 !== 0 || req0 !== 0) begin
      failures++; $display("FAIL boot_ignores_rvalid: valid=%b req=%b required 0 0", valid0, req0);
    end
    tick();
    rvalid = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_sequential();
    test_compr();
    test_redirect_wait();
    test_priority();
    test_misalign();
    test_wrap();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
